// File: rtl/rv_pkg.sv
// Shared RISC-V encodings and access-size helpers for the memory/write-back stage.
package rv_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  // Undefined funct3 encodings fall back to a full word access.
  function automatic size_e access_size(input logic is_load, input logic [2:0] funct3);
    size_e sz;
    sz = SZ_W;
    case (funct3)
      F3_B:    sz = SZ_B;
      F3_H:    sz = SZ_H;
      F3_W:    sz = SZ_W;
      F3_BU:   sz = is_load ? SZ_B : SZ_W;
      F3_HU:   sz = is_load ? SZ_H : SZ_W;
      default: sz = SZ_W;
    endcase
    return sz;
  endfunction

  function automatic logic is_misaligned(input size_e sz, input logic [1:0] off);
    logic mis;
    case (sz)
      SZ_H:    mis = off[0];
      SZ_W:    mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-memory request/ready port; master is the pipeline stage, slave the memory.
interface mem_wb_stage_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [31:0]       dmem_wdata;
  logic [3:0]        dmem_wstrb;
  logic              dmem_ready;
  logic [31:0]       dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/load_extend.sv
// Selects the addressed byte/half of a load word and sign- or zero-extends it.
module load_extend
  import rv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data = {24'b0, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data = {16'b0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access / write-back stage: ALU write-back, loads and stores over a ready handshake.
// Optional abort on a stuck access is enabled with `define MEM_TIMEOUT_EN (adds bus_error).
module mem_wb_stage
  import rv_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ex_valid,
  input  logic [31:0]         ex_alu_result,
  input  logic [31:0]         ex_store_data,
  input  logic [4:0]          ex_rd,
  input  logic [6:0]          ex_opcode,
  input  logic [2:0]          ex_funct3,
  output logic                mem_stall,
  mem_wb_stage_if.master      dmem,
  output logic                wb_reg_write,
  output logic [4:0]          wb_write_reg,
  output logic [31:0]         wb_write_data,
`ifdef MEM_TIMEOUT_EN
  output logic                bus_error,
`endif
  output logic                misaligned
);

  if (ADDR_W > 32 || ADDR_W < 3 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("mem_wb_stage: ADDR_W must be 3..32 and TIMEOUT_CYCLES at least 1");
  end

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        off_q, off_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [4:0]        rd_q, rd_d;
  logic [2:0]        f3_q, f3_d;
  logic              wb_reg_write_q, wb_reg_write_d;
  logic [4:0]        wb_write_reg_q, wb_write_reg_d;
  logic [31:0]       wb_write_data_q, wb_write_data_d;
  logic              misaligned_q, misaligned_d;
  logic [31:0]       load_data;
  logic              is_load;
  size_e             sz;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              bus_error_q, bus_error_d;
`endif

  // Offset and funct3 are latched at accept so the word can be sliced when ready arrives.
  load_extend u_load_extend (
    .rdata  (dmem.dmem_rdata),
    .addr   (off_q),
    .funct3 (f3_q),
    .data   (load_data)
  );

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    off_d           = off_q;
    we_d            = we_q;
    wdata_d         = wdata_q;
    wstrb_d         = wstrb_q;
    rd_d            = rd_q;
    f3_d            = f3_q;
    wb_reg_write_d  = 1'b0;
    wb_write_reg_d  = wb_write_reg_q;
    wb_write_data_d = wb_write_data_q;
    misaligned_d    = 1'b0;
    is_load         = (ex_opcode == LOAD);
    sz              = access_size(is_load, ex_funct3);
`ifdef MEM_TIMEOUT_EN
    cnt_d           = '0;
    bus_error_d     = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (ex_valid) begin
          case (ex_opcode)
            OP, OP_IMM, LUI, AUIPC, JAL, JALR: begin
              wb_reg_write_d  = (ex_rd != 5'd0);
              wb_write_reg_d  = ex_rd;
              wb_write_data_d = ex_alu_result;
            end
            LOAD, STORE: begin
              if (is_misaligned(sz, ex_alu_result[1:0])) begin
                misaligned_d = 1'b1;
              end else begin
                state_d = ST_ACCESS;
                addr_d  = {ex_alu_result[ADDR_W-1:2], 2'b00};
                off_d   = ex_alu_result[1:0];
                we_d    = !is_load;
                rd_d    = ex_rd;
                f3_d    = ex_funct3;
                // Store data is lane-replicated so any byte lane the strobe selects carries it.
                case (sz)
                  SZ_B: begin
                    wdata_d = {4{ex_store_data[7:0]}};
                    wstrb_d = 4'b0001 << ex_alu_result[1:0];
                  end
                  SZ_H: begin
                    wdata_d = {2{ex_store_data[15:0]}};
                    wstrb_d = 4'b0011 << ex_alu_result[1:0];
                  end
                  default: begin
                    wdata_d = ex_store_data;
                    wstrb_d = 4'b1111;
                  end
                endcase
                if (is_load) begin
                  wstrb_d = 4'b0000;
                end
              end
            end
            BRANCH:  ;
            default: ;
          endcase
        end
      end

      ST_ACCESS: begin
        if (dmem.dmem_ready) begin
          state_d = ST_IDLE;
          if (!we_q) begin
            wb_reg_write_d  = (rd_q != 5'd0);
            wb_write_reg_d  = rd_q;
            wb_write_data_d = load_data;
          end
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d     = ST_IDLE;
          bus_error_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      off_q           <= '0;
      we_q            <= 1'b0;
      wdata_q         <= '0;
      wstrb_q         <= '0;
      rd_q            <= '0;
      f3_q            <= '0;
      wb_reg_write_q  <= 1'b0;
      wb_write_reg_q  <= '0;
      wb_write_data_q <= '0;
      misaligned_q    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q           <= '0;
      bus_error_q     <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      off_q           <= off_d;
      we_q            <= we_d;
      wdata_q         <= wdata_d;
      wstrb_q         <= wstrb_d;
      rd_q            <= rd_d;
      f3_q            <= f3_d;
      wb_reg_write_q  <= wb_reg_write_d;
      wb_write_reg_q  <= wb_write_reg_d;
      wb_write_data_q <= wb_write_data_d;
      misaligned_q    <= misaligned_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q           <= cnt_d;
      bus_error_q     <= bus_error_d;
`endif
    end
  end

  assign mem_stall       = (state_q == ST_ACCESS);
  assign dmem.dmem_req   = (state_q == ST_ACCESS);
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign dmem.dmem_wstrb = wstrb_q;
  assign wb_reg_write    = wb_reg_write_q;
  assign wb_write_reg    = wb_write_reg_q;
  assign wb_write_data   = wb_write_data_q;
  assign misaligned      = misaligned_q;
`ifdef MEM_TIMEOUT_EN
  assign bus_error       = bus_error_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized bench for mem_wb_stage against a transaction-level reference model.
module tb_mem_wb_stage;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned TB_TO  = 4;

  localparam logic [6:0] C_OP     = 7'b0110011;
  localparam logic [6:0] C_OPIMM  = 7'b0010011;
  localparam logic [6:0] C_LUI    = 7'b0110111;
  localparam logic [6:0] C_AUIPC  = 7'b0010111;
  localparam logic [6:0] C_JAL    = 7'b1101111;
  localparam logic [6:0] C_JALR   = 7'b1100111;
  localparam logic [6:0] C_LOAD   = 7'b0000011;
  localparam logic [6:0] C_STORE  = 7'b0100011;
  localparam logic [6:0] C_BRANCH = 7'b1100011;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rd;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic        mem_stall;
  logic        wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;
  logic        misaligned;
`ifdef MEM_TIMEOUT_EN
  logic        bus_error;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_wb_stage_if #(.ADDR_W(ADDR_W)) dmem ();

  mem_wb_stage #(
    .ADDR_W         (ADDR_W),
    .TIMEOUT_CYCLES (TB_TO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ex_valid      (ex_valid),
    .ex_alu_result (ex_alu_result),
    .ex_store_data (ex_store_data),
    .ex_rd         (ex_rd),
    .ex_opcode     (ex_opcode),
    .ex_funct3     (ex_funct3),
    .mem_stall     (mem_stall),
    .dmem          (dmem),
    .wb_reg_write  (wb_reg_write),
    .wb_write_reg  (wb_write_reg),
    .wb_write_data (wb_write_data),
`ifdef MEM_TIMEOUT_EN
    .bus_error     (bus_error),
`endif
    .misaligned    (misaligned)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // 0 = no effect, 1 = register write-back, 2 = load, 3 = store
  function automatic int op_class(input logic [6:0] op);
    if (op == C_OP || op == C_OPIMM || op == C_LUI || op == C_AUIPC || op == C_JAL || op == C_JALR)
      return 1;
    if (op == C_LOAD)  return 2;
    if (op == C_STORE) return 3;
    return 0;
  endfunction

  function automatic int acc_bytes(input bit ld, input logic [2:0] f3);
    if (f3 == 3'd0 || (ld && f3 == 3'd4)) return 1;
    if (f3 == 3'd1 || (ld && f3 == 3'd5)) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] load_model(input logic [31:0] rdata, input int off, input logic [2:0] f3);
    int nb;
    logic [31:0] v;
    nb = acc_bytes(1'b1, f3);
    v  = rdata >> (8 * off);
    if (nb == 1) begin
      v = v & 32'hFF;
      if (f3 == 3'd0 && v >= 32'h80) v = v + 32'hFFFF_FF00;
    end else if (nb == 2) begin
      v = v & 32'hFFFF;
      if (f3 == 3'd1 && v >= 32'h8000) v = v + 32'hFFFF_0000;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  function automatic logic [31:0] store_data_model(input logic [31:0] sd, input int nb);
    if (nb == 1) return (sd & 32'hFF) * 32'h0101_0101;
    if (nb == 2) return (sd & 32'hFFFF) * 32'h0001_0001;
    return sd;
  endfunction

  function automatic logic [31:0] store_strb_model(input int nb, input int off);
    return 32'((((1 << nb) - 1) << off) & 15);
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_we"},  32'(wb_reg_write), 32'd0);
    check({tag, "_mis"}, 32'(misaligned), 32'd0);
    check({tag, "_req"}, 32'(dmem.dmem_req), 32'd0);
  endtask

  // Presents one instruction at a falling edge and follows it until the stage is idle again.
  task automatic run_txn(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] sd, input logic [4:0] rd, input int lat,
                         input logic [31:0] rdata);
    int cls, nb, off;
    cls = op_class(op);
    ex_valid        = 1'b1;
    ex_opcode       = op;
    ex_funct3       = f3;
    ex_alu_result   = alu;
    ex_store_data   = sd;
    ex_rd           = rd;
    dmem.dmem_ready = 1'($urandom_range(0, 1));
    dmem.dmem_rdata = $urandom;
    @(posedge clk);
    @(negedge clk);
    ex_valid        = 1'b0;
    dmem.dmem_ready = 1'b0;
    if (cls == 1) begin
      check("alu_we", 32'(wb_reg_write), 32'(rd != 5'd0));
      if (rd != 5'd0) begin
        check("alu_reg", 32'(wb_write_reg), 32'(rd));
        check("alu_data", wb_write_data, alu);
      end
      check("alu_stall", 32'(mem_stall), 32'd0);
      check("alu_req", 32'(dmem.dmem_req), 32'd0);
    end else if (cls == 0) begin
      check_quiet("nop");
      check("nop_stall", 32'(mem_stall), 32'd0);
    end else begin
      nb  = acc_bytes(cls == 2, f3);
      off = int'(alu[1:0]);
      if ((off % nb) != 0) begin
        check("mis_pulse", 32'(misaligned), 32'd1);
        check("mis_req", 32'(dmem.dmem_req), 32'd0);
        check("mis_we", 32'(wb_reg_write), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("mis_end", 32'(misaligned), 32'd0);
        check("mis_req2", 32'(dmem.dmem_req), 32'd0);
      end else begin
        for (int i = 0; i <= lat; i++) begin
          if (i == lat) begin
            dmem.dmem_ready = 1'b1;
            dmem.dmem_rdata = rdata;
          end
          check("acc_req", 32'(dmem.dmem_req), 32'd1);
          check("acc_stall", 32'(mem_stall), 32'd1);
          check("acc_addr", dmem.dmem_addr, alu & 32'hFFFF_FFFC);
          check("acc_dir", 32'(dmem.dmem_we), 32'(cls == 3));
          if (cls == 3) begin
            check("st_wdata", dmem.dmem_wdata, store_data_model(sd, nb));
            check("st_wstrb", 32'(dmem.dmem_wstrb), store_strb_model(nb, off));
          end
          check("acc_nowb", 32'(wb_reg_write), 32'd0);
          @(posedge clk);
          @(negedge clk);
        end
        dmem.dmem_ready = 1'b0;
        dmem.dmem_rdata = $urandom;
        check("done_req", 32'(dmem.dmem_req), 32'd0);
        check("done_stall", 32'(mem_stall), 32'd0);
`ifdef MEM_TIMEOUT_EN
        check("done_berr", 32'(bus_error), 32'd0);
`endif
        if (cls == 2) begin
          check("ld_we", 32'(wb_reg_write), 32'(rd != 5'd0));
          if (rd != 5'd0) begin
            check("ld_reg", 32'(wb_write_reg), 32'(rd));
            check("ld_data", wb_write_data, load_model(rdata, off, f3));
          end
        end else begin
          check("st_nowb", 32'(wb_reg_write), 32'd0);
        end
      end
    end
  endtask

  logic [6:0] op_tab [10];
  int         max_lat;

  initial begin
    op_tab = '{C_OP, C_OPIMM, C_LUI, C_AUIPC, C_JAL, C_JALR, C_LOAD, C_STORE, C_BRANCH, 7'b1110011};
`ifdef MEM_TIMEOUT_EN
    max_lat = TB_TO - 1;
`else
    max_lat = 5;
`endif
    reset           = 1'b0;
    ex_valid        = 1'b0;
    ex_alu_result   = '0;
    ex_store_data   = '0;
    ex_rd           = '0;
    ex_opcode       = '0;
    ex_funct3       = '0;
    dmem.dmem_ready = 1'b0;
    dmem.dmem_rdata = '0;
    #1;
    check("rst_req", 32'(dmem.dmem_req), 32'd0);
    check("rst_stall", 32'(mem_stall), 32'd0);
    check("rst_we", 32'(wb_reg_write), 32'd0);
    check("rst_reg", 32'(wb_write_reg), 32'd0);
    check("rst_data", wb_write_data, 32'd0);
    check("rst_mis", 32'(misaligned), 32'd0);
    check("rst_addr", dmem.dmem_addr, 32'd0);
    check("rst_wstrb", 32'(dmem.dmem_wstrb), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    run_txn(C_OP, 3'd0, 32'h0000_1234, 32'h0, 5'd5, 0, 32'h0);
    run_txn(C_LOAD, 3'd0, 32'h0000_0103, 32'h0, 5'd7, 3, 32'h80FF_0000);
    run_txn(C_LOAD, 3'd4, 32'h0000_0103, 32'h0, 5'd7, 3, 32'h80FF_0000);
    run_txn(C_STORE, 3'd1, 32'h0000_0202, 32'hDEAD_BEEF, 5'd3, 1, 32'h0);
    run_txn(C_LOAD, 3'd2, 32'h0000_0101, 32'h0, 5'd9, 0, 32'h0);
    run_txn(C_LOAD, 3'd2, 32'h0000_0104, 32'h0, 5'd0, 1, 32'h1234_5678);
    run_txn(C_BRANCH, 3'd0, 32'h0000_0040, 32'h0, 5'd4, 0, 32'h0);
    run_txn(C_LUI, 3'd0, 32'hABCD_E000, 32'h0, 5'd0, 0, 32'h0);

    // Reset in the middle of an outstanding access.
    ex_valid = 1'b1; ex_opcode = C_LOAD; ex_funct3 = 3'd2; ex_alu_result = 32'h300;
    ex_rd = 5'd6;
    @(posedge clk);
    @(negedge clk);
    ex_valid = 1'b0;
    check("pre_rst_req", 32'(dmem.dmem_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("arst_req", 32'(dmem.dmem_req), 32'd0);
    check("arst_stall", 32'(mem_stall), 32'd0);
    check("arst_we", 32'(wb_reg_write), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    run_txn(C_OPIMM, 3'd0, 32'h0000_0055, 32'h0, 5'd12, 0, 32'h0);

`ifdef MEM_TIMEOUT_EN
    ex_valid = 1'b1; ex_opcode = C_LOAD; ex_funct3 = 3'd2; ex_alu_result = 32'h400;
    ex_rd = 5'd8;
    @(posedge clk);
    @(negedge clk);
    ex_valid = 1'b0;
    for (int i = 0; i < int'(TB_TO); i++) begin
      check("to_req", 32'(dmem.dmem_req), 32'd1);
      check("to_berr0", 32'(bus_error), 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    check("to_berr", 32'(bus_error), 32'd1);
    check("to_req_drop", 32'(dmem.dmem_req), 32'd0);
    check("to_stall", 32'(mem_stall), 32'd0);
    check("to_nowb", 32'(wb_reg_write), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("to_berr_end", 32'(bus_error), 32'd0);
    check("to_nowb2", 32'(wb_reg_write), 32'd0);
`endif

    for (int n = 0; n < 300; n++) begin
      logic [6:0]  op;
      logic [4:0]  rd;
      op = op_tab[$urandom_range(0, 9)];
      if ($urandom_range(0, 3) == 0) op = C_LOAD;
      if ($urandom_range(0, 4) == 0) op = C_STORE;
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      run_txn(op, 3'($urandom), $urandom, $urandom, rd, $urandom_range(0, max_lat), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
